// File: rtl/byte_encode_stream_if.sv
// Coefficient-in / byte-out stream bundle for byte_encode_stream.
// The packer connects through the master modport; the surrounding logic uses slave.
interface byte_encode_stream_if;

    localparam int unsigned COEFF_W = 12;
    localparam int unsigned BYTE_W  = 8;

    logic               coeff_valid;
    logic               coeff_ready;
    logic [COEFF_W-1:0] coeff_data;
    logic               byte_valid;
    logic               byte_ready;
    logic [BYTE_W-1:0]  byte_data;
    logic               byte_last;

    // Packer side: consumes coefficients, produces bytes.
    modport master (
        input  coeff_valid,
        input  coeff_data,
        input  byte_ready,
        output coeff_ready,
        output byte_valid,
        output byte_data,
        output byte_last
    );

    // Environment side: supplies coefficients, sinks bytes.
    modport slave (
        output coeff_valid,
        output coeff_data,
        output byte_ready,
        input  coeff_ready,
        input  byte_valid,
        input  byte_data,
        input  byte_last
    );

endinterface

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_ELL packer: NUM_COEFFS coefficients of ELL bits in,
// NUM_COEFFS*ELL/8 little-endian packed bytes out.
// Optional feature macro ENCODE_MODQ_EN: for ELL==12, coefficients >= 3329 get
// one conditional subtraction of 3329 before packing.
module byte_encode_stream #(
    parameter int unsigned ELL        = 12,
    parameter int unsigned NUM_COEFFS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    byte_encode_stream_if.master  bus,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned ACC_W     = 20;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = (NUM_COEFFS * ELL) / 8;
    localparam int unsigned CCNT_W    = $clog2(NUM_COEFFS + 1);
    localparam int unsigned BCNT_W    = $clog2(NUM_BYTES + 1);
    localparam int unsigned Q         = 3329;

    // Reject configurations the accumulator sizing cannot handle.
    if (ELL < 1 || ELL > 12 || ((NUM_COEFFS * ELL) % 8) != 0) begin : g_bad_param
        $error("byte_encode_stream: illegal ELL/NUM_COEFFS combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state,  state_n;
    logic [ACC_W-1:0]    acc,    acc_n;
    logic [CNT_W-1:0]    cnt,    cnt_n;
    logic [CCNT_W-1:0]   ccnt,   ccnt_n;
    logic [BCNT_W-1:0]   bcnt,   bcnt_n;

    logic                coeff_ready_reg, coeff_ready_n;
    logic                byte_valid_reg,  byte_valid_n;
    logic [BYTE_W-1:0]   byte_data_reg,   byte_data_n;
    logic                byte_last_reg,   byte_last_n;
    logic                busy_n;
    logic                done_n;

    logic                coeff_take;
    logic                byte_take;
    logic [ELL-1:0]      coeff_in;
    logic                unused_coeff_bits;

    // Upper coefficient bits are don't-care unless the modular reduction uses them.
    assign unused_coeff_bits = ^bus.coeff_data;

    // Coefficient value that actually enters the accumulator.
`ifdef ENCODE_MODQ_EN
    if (ELL == 12) begin : g_modq
        assign coeff_in = (bus.coeff_data >= 12'(Q)) ? ELL'(bus.coeff_data - 12'(Q))
                                                     : ELL'(bus.coeff_data);
    end else begin : g_trunc
        assign coeff_in = bus.coeff_data[ELL-1:0];
    end
`else
    assign coeff_in = bus.coeff_data[ELL-1:0];
`endif

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            acc             <= '0;
            cnt             <= '0;
            ccnt            <= '0;
            bcnt            <= '0;
            coeff_ready_reg <= 1'b0;
            byte_valid_reg  <= 1'b0;
            byte_data_reg   <= '0;
            byte_last_reg   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_n;
            acc             <= acc_n;
            cnt             <= cnt_n;
            ccnt            <= ccnt_n;
            bcnt            <= bcnt_n;
            coeff_ready_reg <= coeff_ready_n;
            byte_valid_reg  <= byte_valid_n;
            byte_data_reg   <= byte_data_n;
            byte_last_reg   <= byte_last_n;
            busy            <= busy_n;
            done            <= done_n;
        end
    end

    // Next state, accumulator update and next values of the registered outputs.
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        ccnt_n     = ccnt;
        bcnt_n     = bcnt;
        coeff_take = 1'b0;
        byte_take  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                    acc_n   = '0;
                    cnt_n   = '0;
                    ccnt_n  = '0;
                    bcnt_n  = '0;
                end
            end
            S_RUN: begin
                // ready (cnt<8) and valid (cnt>=8) never overlap, so at most one fires
                coeff_take = coeff_ready_reg & bus.coeff_valid;
                byte_take  = byte_valid_reg & bus.byte_ready;
                if (coeff_take) begin
                    acc_n  = acc | (ACC_W'(coeff_in) << cnt);
                    cnt_n  = cnt + CNT_W'(ELL);
                    ccnt_n = ccnt + CCNT_W'(1);
                end else if (byte_take) begin
                    acc_n  = acc >> BYTE_W;
                    cnt_n  = cnt - CNT_W'(BYTE_W);
                    bcnt_n = bcnt + BCNT_W'(1);
                    if (bcnt == BCNT_W'(NUM_BYTES - 1)) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        coeff_ready_n = (state_n == S_RUN) && (cnt_n < CNT_W'(BYTE_W))
                        && (ccnt_n < CCNT_W'(NUM_COEFFS));
        byte_valid_n  = (state_n == S_RUN) && (cnt_n >= CNT_W'(BYTE_W));
        byte_data_n   = acc_n[BYTE_W-1:0];
        byte_last_n   = byte_valid_n && (bcnt_n == BCNT_W'(NUM_BYTES - 1));
        busy_n        = (state_n != S_IDLE);
        done_n        = (state_n == S_DONE);
    end

    // Drive the stream bundle from the output registers.
    assign bus.coeff_ready = coeff_ready_reg;
    assign bus.byte_valid  = byte_valid_reg;
    assign bus.byte_data   = byte_data_reg;
    assign bus.byte_last   = byte_last_reg;

endmodule

// File: tb/tb_byte_encode_stream.sv
// Directed bench for byte_encode_stream: four instances with different ELL/NUM_COEFFS
// share one stimulus bus; only the instance that was started reacts to it.
module tb_byte_encode_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    wire  [3:0]  busy_v;
    wire  [3:0]  done_v;
    logic        coeff_valid;
    logic [11:0] coeff_data;
    logic        byte_ready;
    int          sel;

    logic        m_cr;
    logic        m_bv;
    logic [7:0]  m_bd;
    logic        m_bl;

    logic [11:0] cin   [256];
    logic [7:0]  exp_b [384];

    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    byte_encode_stream_if if8();
    byte_encode_stream_if if12();
    byte_encode_stream_if if4();
    byte_encode_stream_if ifb();

    assign if8.coeff_valid  = coeff_valid;
    assign if8.coeff_data   = coeff_data;
    assign if8.byte_ready   = byte_ready;
    assign if12.coeff_valid = coeff_valid;
    assign if12.coeff_data  = coeff_data;
    assign if12.byte_ready  = byte_ready;
    assign if4.coeff_valid  = coeff_valid;
    assign if4.coeff_data   = coeff_data;
    assign if4.byte_ready   = byte_ready;
    assign ifb.coeff_valid  = coeff_valid;
    assign ifb.coeff_data   = coeff_data;
    assign ifb.byte_ready   = byte_ready;

    byte_encode_stream #(.ELL(8), .NUM_COEFFS(32)) u_e8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bus(if8),
        .busy(busy_v[0]), .done(done_v[0]));
    byte_encode_stream #(.ELL(12), .NUM_COEFFS(2)) u_e12 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bus(if12),
        .busy(busy_v[1]), .done(done_v[1]));
    byte_encode_stream #(.ELL(4), .NUM_COEFFS(2)) u_e4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .bus(if4),
        .busy(busy_v[2]), .done(done_v[2]));
    byte_encode_stream #(.ELL(12), .NUM_COEFFS(256)) u_big (
        .clk(clk), .rst(rst), .start(start_v[3]), .bus(ifb),
        .busy(busy_v[3]), .done(done_v[3]));

    // Observe the outputs of the instance under test.
    always_comb begin
        m_cr = 1'b0;
        m_bv = 1'b0;
        m_bd = 8'h00;
        m_bl = 1'b0;
        case (sel)
            0: begin m_cr = if8.coeff_ready;  m_bv = if8.byte_valid;  m_bd = if8.byte_data;  m_bl = if8.byte_last;  end
            1: begin m_cr = if12.coeff_ready; m_bv = if12.byte_valid; m_bd = if12.byte_data; m_bl = if12.byte_last; end
            2: begin m_cr = if4.coeff_ready;  m_bv = if4.byte_valid;  m_bd = if4.byte_data;  m_bl = if4.byte_last;  end
            default: begin m_cr = ifb.coeff_ready; m_bv = ifb.byte_valid; m_bd = ifb.byte_data; m_bl = ifb.byte_last; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Start instance s, stream cin[] in and compare bytes against exp_b[].
    task automatic run_frame(input int s, input int ncoef, input int nbyte, input int stall_at,
                             input int stall_len, input int abort_at, input int want_cycles,
                             input string name);
        int ci;
        int bi;
        int cyc;
        int stall_n;
        sel = s;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
        check($sformatf("%s_busy_on", name), 32'(busy_v[s]), 32'd1);
        check($sformatf("%s_cready_on", name), 32'(m_cr), 32'd1);
        ci = 0;
        bi = 0;
        cyc = 0;
        stall_n = 0;
        while (bi < nbyte && bi != abort_at && cyc < 4000) begin
            coeff_valid = (ci < ncoef);
            coeff_data  = (ci < ncoef) ? cin[ci] : 12'h000;
            byte_ready  = 1'b1;
            if (bi == stall_at && stall_n < stall_len && (m_bv || stall_n > 0)) begin
                byte_ready = 1'b0;
                stall_n++;
                check($sformatf("%s_stall_valid", name), 32'(m_bv), 32'd1);
                check($sformatf("%s_stall_data", name), 32'(m_bd), 32'(exp_b[bi]));
                check($sformatf("%s_stall_cready", name), 32'(m_cr), 32'd0);
            end
            if (coeff_valid && m_cr) ci++;
            if (m_bv && byte_ready) begin
                check($sformatf("%s_byte%0d", name, bi), 32'(m_bd), 32'(exp_b[bi]));
                check($sformatf("%s_last%0d", name, bi), 32'(m_bl), 32'(bi == nbyte - 1));
                bi++;
            end
            @(negedge clk);
            cyc++;
        end
        coeff_valid = 1'b0;
        byte_ready  = 1'b1;
        if (cyc >= 4000) begin
            check($sformatf("%s_timeout_bytes", name), 32'(bi), 32'(nbyte));
        end else if (abort_at < 0) begin
            if (want_cycles > 0) check($sformatf("%s_cycles", name), 32'(cyc), 32'(want_cycles));
            check($sformatf("%s_done_pulse", name), 32'(done_v[s]), 32'd1);
            check($sformatf("%s_busy_in_done", name), 32'(busy_v[s]), 32'd1);
            check($sformatf("%s_valid_in_done", name), 32'(m_bv), 32'd0);
            @(negedge clk);
            check($sformatf("%s_done_low", name), 32'(done_v[s]), 32'd0);
            check($sformatf("%s_busy_low", name), 32'(busy_v[s]), 32'd0);
        end
    endtask

    task automatic set3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
    endtask

    initial begin
        int v;
        int bit_idx;
        rst         = 1'b1;
        start_v     = '0;
        coeff_valid = 1'b0;
        coeff_data  = 12'h000;
        byte_ready  = 1'b1;
        sel         = 0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_cready", 32'(m_cr), 32'd0);
        check("rst_bvalid", 32'(m_bv), 32'd0);
        check("rst_bdata", 32'(m_bd), 32'd0);
        check("rst_blast", 32'(m_bl), 32'd0);
        check("rst_busy", 32'(busy_v), 32'd0);
        check("rst_done", 32'(done_v), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ELL=8: output bytes equal the input coefficients, 2 cycles per coefficient.
        cin[0] = 12'h049; cin[1] = 12'h08B; cin[2] = 12'h00B; cin[3] = 12'h0FF;
        for (int i = 4; i < 32; i++) cin[i] = 12'((i * 37 + 5) & 8'hFF);
        for (int i = 0; i < 32; i++) exp_b[i] = cin[i][7:0];
        run_frame(0, 32, 32, -1, 0, -1, 64, "e8");

        // ELL=12: 0x001,0x002 -> 01 20 00.
        cin[0] = 12'h001; cin[1] = 12'h002;
        set3(8'h01, 8'h20, 8'h00);
        run_frame(1, 2, 3, -1, 0, -1, 5, "e12_small");

        // ELL=12: 4095 is either reduced to 766 or packed raw.
        cin[0] = 12'hFFF; cin[1] = 12'h000;
`ifdef ENCODE_MODQ_EN
        set3(8'hFE, 8'h02, 8'h00);
`else
        set3(8'hFF, 8'h0F, 8'h00);
`endif
        run_frame(1, 2, 3, -1, 0, -1, 5, "e12_4095");

        // ELL=12: 3329 is the reduction boundary (maps to zero).
        cin[0] = 12'd3329; cin[1] = 12'h000;
`ifdef ENCODE_MODQ_EN
        set3(8'h00, 8'h00, 8'h00);
`else
        set3(8'h01, 8'h0D, 8'h00);
`endif
        run_frame(1, 2, 3, -1, 0, -1, 5, "e12_q");

        // ELL=4: upper coefficient bits ignored; 0x3,0xA -> A3, single last byte.
        cin[0] = 12'hFF3; cin[1] = 12'h70A;
        exp_b[0] = 8'hA3;
        run_frame(2, 2, 1, -1, 0, -1, 3, "e4");

        // ELL=12, 256 coefficients with a 10-cycle sink stall mid-frame.
        for (int k = 0; k < 384; k++) exp_b[k] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = (i * 1237 + 55) % 4096;
            cin[i] = 12'(v);
`ifdef ENCODE_MODQ_EN
            if (v >= 3329) v = v - 3329;
`endif
            for (int j = 0; j < 12; j++) begin
                bit_idx = i * 12 + j;
                exp_b[bit_idx / 8][bit_idx % 8] = v[j];
            end
        end
        run_frame(3, 256, 384, 100, 10, -1, 0, "big");

        // Abort an ELL=8 frame after 5 bytes with a byte pending, then rerun cleanly.
        for (int i = 0; i < 32; i++) begin
            cin[i]   = 12'(8'h80 + i);
            exp_b[i] = 8'(8'h80 + i);
        end
        run_frame(0, 32, 32, -1, 0, 5, 0, "abort");
        coeff_valid = 1'b1;
        coeff_data  = cin[5];
        @(negedge clk);
        coeff_valid = 1'b0;
        check("abort_pending_valid", 32'(m_bv), 32'd1);
        check("abort_pending_data", 32'(m_bd), 32'h85);
        rst = 1'b1;
        #1;
        check("abort_rst_cready", 32'(m_cr), 32'd0);
        check("abort_rst_bvalid", 32'(m_bv), 32'd0);
        check("abort_rst_bdata", 32'(m_bd), 32'd0);
        check("abort_rst_blast", 32'(m_bl), 32'd0);
        check("abort_rst_busy", 32'(busy_v[0]), 32'd0);
        check("abort_rst_done", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        coeff_valid = 1'b1;
        coeff_data  = 12'h055;
        repeat (2) @(negedge clk);
        coeff_valid = 1'b0;
        check("abort_idle_busy", 32'(busy_v[0]), 32'd0);
        check("abort_idle_cready", 32'(m_cr), 32'd0);
        for (int i = 0; i < 32; i++) begin
            cin[i]   = 12'(i);
            exp_b[i] = 8'(i);
        end
        run_frame(0, 32, 32, -1, 0, -1, 64, "fresh");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
